cell_pattern_sequencer: RTL
===========================

Name: cell_pattern_sequencer

Overview:
- Parametrised successor to the two-cell switch-driven cell indicator. Drives NUM_CELLS test cells, each PIXELS pixels wide, plus an opcode to the cell processor.
- Adds a per-cell colour-code register file, a valid/ready issue handshake, completion wait with timeout, and three issue modes: single-shot, continuous, and walking-pixel.
- Sits between the switch debouncer and the cell processor input.

Parameters:
- NUM_CELLS, 2, number of cells driven (1..16).
- PIXELS, 9, pixels per cell.
- CH_W, 8, bits per colour channel; pixel width is 3*CH_W.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for ResultValid after an accepted op.
- GAP_CYCLES, 16, idle cycles between ops in the continuous and walk modes (minimum 1).

Ports:
- SYSCLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- DebouncedSwitches  in  16  [15:12] opcode, [11:10] mode, [7:4] cell index, [3:0] colour code.
- LoadBtn  in  1  debounced level; its rising edge writes code [3:0] to cell [7:4].
- GoBtn  in  1  debounced level; its rising edge starts issue.
- CellData  out  NUM_CELLS*PIXELS*3*CH_W  flattened; cell 0, pixel 0 in the LSBs.
- Opcode  out  4  opcode presented with CellData.
- OpValid  out  1  request valid.
- OpReady  in  1  processor accepts when OpValid && OpReady.
- ResultValid  in  1  one-cycle completion pulse from the processor.
- Busy  out  1  high in any state other than IDLE.
- OpCount  out  16  count of completed ops; wraps at 16'hFFFF.
- Timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (RST=0, asynchronous): all outputs and registers are cleared immediately.
  - Code registers = 4'h0 (WHITE); CellData = all WHITE; Opcode=0; OpValid=0; Busy=0; OpCount=0; Timeout=0.
  - Rotation offset=0; state=IDLE; edge-detect registers=0.
  - Reset mid-operation abandons the op with no completion counted.
- Edge detection: LoadBtn and GoBtn are registered once; a rising edge is current=1 and previous=0.
- Load:
  - On a LoadBtn edge with index < NUM_CELLS, code[index] <= switches[3:0] one cycle later.
  - Index >= NUM_CELLS is ignored.
  - Load is accepted in every state.
- Colour map (3*CH_W pixel, channel full = all ones):
  - 0001 BLACK; 0011 RED; 0100 LIME; 0101 BLUE; 0010 GRAY (MSB of each channel only); anything else WHITE.
- Modes: 00 single-shot; 01 continuous; 10 walk; 11 treated as 00.
- State IDLE:
  - A GoBtn edge snapshots the code registers, opcode and mode into shadow registers, then goes to ISSUE.
  - A GoBtn edge also clears Timeout.
  - GoBtn edges outside IDLE are ignored.
- State ISSUE:
  - OpValid=1; CellData and Opcode are driven from the shadow and are stable until acceptance.
  - On OpValid && OpReady, go to WAIT and clear the timeout counter.
  - OpReady already high on ISSUE entry means acceptance in the first ISSUE cycle.
- State WAIT:
  - OpValid=0.
  - On ResultValid: OpCount+1; in walk mode, offset <= (offset+1) mod PIXELS.
    - Then: mode 00/11 goes to IDLE; modes 01/10 go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ResultValid: Timeout=1, go to IDLE, no count.
  - ResultValid arriving in the same cycle as the timeout terminal count is treated as success.
- State GAP:
  - Counts GAP_CYCLES, then re-snapshots codes, opcode and mode, and goes to ISSUE.
  - If the live mode is 00/11 at GAP end, go to IDLE instead. Continuous/walk stop this way without disturbing an in-flight op.
- Walk pattern:
  - Pixel p of a cell is the cell colour if p == offset, otherwise BLACK.
  - Non-walk modes fill every pixel with the cell colour.
  - Offset resets to 0 whenever a new run starts from IDLE.
- Load/snapshot collision: a Load in the same cycle as a snapshot is not captured by that snapshot. It is visible at the next snapshot.
- CellData outside ISSUE holds the last-issued value (WHITE after reset).
- Latency: GoBtn rise to OpValid = 3 SYSCLK (sync, edge, snapshot).

Decomposition:
- Package image_proc_pkg:
  - color_code_t (4-bit) and colour-code constants.
  - mode_t enum.
  - seq_state_t enum {IDLE, ISSUE, WAIT, GAP}.
  - Function color_lookup(code, CH_W).
- Sub-module cell_pixel_packer: combinational; shadow codes + offset + walk flag -> flattened CellData.
- FSM, counters and register file live in the top.

Test Plan:
- Reset, then Load cell1 code 0011 and cell0 code 0101, mode 00, opcode 4'h6, Go, OpReady=1 -> OpValid rises 3 cycles after Go. CellData cell0 pixels = 24'h0000FF, cell1 = 24'hFF0000, Opcode=6. ResultValid -> OpCount=1, Busy=0.
- Hold OpReady=0 for 10 cycles during ISSUE, and Load a new code meanwhile -> CellData and OpValid held unchanged for all 10 cycles; the new code appears only on the next issue.
- Mode 10, PIXELS=9, cell0 code 0100, 11 completions -> lit pixel index sequence 0,1,...,8,0,1. Only the lit pixel = 24'h00FF00, others 24'h000000.
- Mode 01, switch to 00 during WAIT -> current op completes, GAP runs, then IDLE with no further OpValid. OpCount incremented once.
- No ResultValid after acceptance -> Timeout=1 after TIMEOUT_CYCLES cycles, IDLE, OpCount unchanged. Next Go clears Timeout.
- Assert RST low mid-WAIT -> all outputs at reset values in the same cycle, asynchronously. Load index 15 with NUM_CELLS=2 -> no register changes.

Source files
------------

// File: rtl/image_proc_pkg.sv
// Shared types and colour decoding for the cell pattern sequencer.
package image_proc_pkg;

    typedef logic [3:0] color_code_t;

    localparam color_code_t CODE_WHITE = 4'h0;
    localparam color_code_t CODE_BLACK = 4'h1;
    localparam color_code_t CODE_GRAY  = 4'h2;
    localparam color_code_t CODE_RED   = 4'h3;
    localparam color_code_t CODE_LIME  = 4'h4;
    localparam color_code_t CODE_BLUE  = 4'h5;

    localparam int unsigned MAX_CH_W = 32;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_WALK   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} seq_state_t;

    // Result is {R,G,B} packed into the low 3*chW bits; callers truncate.
    function automatic logic [3*MAX_CH_W-1:0] color_lookup(input color_code_t code,
                                                           input int unsigned chW);
        logic [3*MAX_CH_W-1:0] full;
        logic [3*MAX_CH_W-1:0] msb;
        full = ~({(3*MAX_CH_W){1'b1}} << chW);
        msb  = full ^ (full >> 1);
        case (code)
            CODE_BLACK: color_lookup = '0;
            CODE_RED:   color_lookup = full << (2 * chW);
            CODE_LIME:  color_lookup = full << chW;
            CODE_BLUE:  color_lookup = full;
            CODE_GRAY:  color_lookup = (msb << (2 * chW)) | (msb << chW) | msb;
            default:    color_lookup = (full << (2 * chW)) | (full << chW) | full;
        endcase
    endfunction

endpackage

// File: rtl/cell_pixel_packer.sv
// Expands per-cell colour codes into the flattened pixel bus, with optional walking pixel.
module cell_pixel_packer
    import image_proc_pkg::*;
#(
    parameter int unsigned NUM_CELLS = 2,
    parameter int unsigned PIXELS    = 9,
    parameter int unsigned CH_W      = 8,
    parameter int unsigned OFF_W     = 4
) (
    input  color_code_t                            codes [NUM_CELLS],
    input  logic [OFF_W-1:0]                       offset,
    input  logic                                   walk,
    output logic [NUM_CELLS*PIXELS*3*CH_W-1:0]     cellData
);

    localparam int unsigned PIX_W = 3 * CH_W;

    always_comb begin
        cellData = '0;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            for (int unsigned p = 0; p < PIXELS; p++) begin
                if (!walk || p == 32'(offset))
                    cellData[(c*PIXELS+p)*PIX_W +: PIX_W] = PIX_W'(color_lookup(codes[c], CH_W));
            end
        end
    end

endmodule

// File: rtl/cell_pattern_sequencer.sv
// Colour-code register file plus issue FSM driving test cells into the cell processor.
module cell_pattern_sequencer
    import image_proc_pkg::*;
#(
    parameter int unsigned NUM_CELLS      = 2,
    parameter int unsigned PIXELS         = 9,
    parameter int unsigned CH_W           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic                                SYSCLK,
    input  logic                                RST,
    input  logic [15:0]                         DebouncedSwitches,
    input  logic                                LoadBtn,
    input  logic                                GoBtn,
    output logic [NUM_CELLS*PIXELS*3*CH_W-1:0]  CellData,
    output logic [3:0]                          Opcode,
    output logic                                OpValid,
    input  logic                                OpReady,
    input  logic                                ResultValid,
    output logic                                Busy,
    output logic [15:0]                         OpCount,
    output logic                                Timeout
);

    localparam int unsigned OFF_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [OFF_W-1:0] OFF_LAST     = OFF_W'(PIXELS - 1);

    seq_state_t        state;
    color_code_t       codeReg    [NUM_CELLS];
    color_code_t       shadowCode [NUM_CELLS];
    mode_t             shadowMode;
    mode_t             liveMode;
    logic [OFF_W-1:0]  offset;
    logic [OFF_W-1:0]  shadowOffset;
    logic [CNT_W-1:0]  cnt;
    logic              loadSync, loadPrev, loadEdge;
    logic              goSync, goPrev, goEdge;
    logic              snapFromIdle, snapFromGap;
    logic              unusedSwBits;

    assign unusedSwBits = ^DebouncedSwitches[9:8];

    always_comb begin
        liveMode = mode_t'(DebouncedSwitches[11:10]);
        if (liveMode == MODE_RSVD)
            liveMode = MODE_SINGLE;
    end

    assign snapFromIdle = (state == IDLE) && goEdge;
    assign snapFromGap  = (state == GAP) && (cnt == GAP_LAST) && (liveMode != MODE_SINGLE);
    assign Busy         = (state != IDLE);

    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            shadowMode   <= MODE_SINGLE;
            offset       <= '0;
            shadowOffset <= '0;
            cnt          <= '0;
            Opcode       <= '0;
            OpValid      <= 1'b0;
            OpCount      <= '0;
            Timeout      <= 1'b0;
            loadSync     <= 1'b0;
            loadPrev     <= 1'b0;
            loadEdge     <= 1'b0;
            goSync       <= 1'b0;
            goPrev       <= 1'b0;
            goEdge       <= 1'b0;
            for (int unsigned c = 0; c < NUM_CELLS; c++) begin
                codeReg[c]    <= CODE_WHITE;
                shadowCode[c] <= CODE_WHITE;
            end
        end else begin
            loadSync <= LoadBtn;
            loadPrev <= loadSync;
            loadEdge <= loadSync & ~loadPrev;
            goSync   <= GoBtn;
            goPrev   <= goSync;
            goEdge   <= goSync & ~goPrev;

            if (loadEdge) begin
                for (int unsigned c = 0; c < NUM_CELLS; c++)
                    if (32'(DebouncedSwitches[7:4]) == c)
                        codeReg[c] <= DebouncedSwitches[3:0];
            end

            // Snapshot reads codeReg before this cycle's load lands.
            if (snapFromIdle || snapFromGap) begin
                for (int unsigned c = 0; c < NUM_CELLS; c++)
                    shadowCode[c] <= codeReg[c];
                Opcode       <= DebouncedSwitches[15:12];
                shadowMode   <= liveMode;
                shadowOffset <= snapFromIdle ? '0 : offset;
            end

            case (state)
                IDLE: begin
                    if (goEdge) begin
                        offset  <= '0;
                        Timeout <= 1'b0;
                        OpValid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (OpReady) begin
                        OpValid <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (ResultValid) begin
                        OpCount <= OpCount + 16'd1;
                        if (shadowMode == MODE_WALK)
                            offset <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
                        if (shadowMode == MODE_SINGLE) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= GAP;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        Timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (liveMode == MODE_SINGLE) begin
                            state <= IDLE;
                        end else begin
                            OpValid <= 1'b1;
                            state   <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cell_pixel_packer #(
        .NUM_CELLS (NUM_CELLS),
        .PIXELS    (PIXELS),
        .CH_W      (CH_W),
        .OFF_W     (OFF_W)
    ) u_packer (
        .codes    (shadowCode),
        .offset   (shadowOffset),
        .walk     (shadowMode == MODE_WALK),
        .cellData (CellData)
    );

endmodule
